// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared constants and FSM state type for the AXI4-Lite write front end
package axil_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/axil_strb_regfile.sv
// rtl/axil_strb_regfile.sv - NUM_REGS x 32 register file with byte-strobe write port
// and combinational read port; out-of-range read indices return zero.
module axil_strb_regfile
  import axil_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // A power-of-two depth makes every index legal, so the range guard is only built otherwise.
  generate
    if (NUM_REGS == (1 << IDX_W)) begin : g_full
      assign o_rd_data = r_mem[i_rd_idx];
    end else begin : g_partial
      localparam logic [IDX_W:0] LIMIT = (IDX_W + 1)'(NUM_REGS);
      assign o_rd_data = ({1'b0, i_rd_idx} < LIMIT) ? r_mem[i_rd_idx] : '0;
    end
  endgenerate

endmodule

// File: rtl/axil_write_slave_ctrl.sv
// rtl/axil_write_slave_ctrl.sv - AXI4-Lite write front end: AW/W capture, strobed commit, B response.
// Define AXIL_ALIGN_CHECK_EN to reject AWADDR[1:0] != 0 with SLVERR.
module axil_write_slave_ctrl
  import axil_pkg::*;
#(
  parameter  int ADDR_W   = 8,
  parameter  int NUM_REGS = 16,
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  output logic              wr_pulse,
  output logic [IDX_W-1:0]  wr_index,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-2:0] NUM_REGS_L = (ADDR_W - 1)'(NUM_REGS);

  state_t             r_state;
  logic               r_aw_cap;
  logic               r_w_cap;
  logic [ADDR_W-1:0]  r_awaddr;
  logic [DATA_W-1:0]  r_wdata;
  logic [STRB_W-1:0]  r_wstrb;
  logic               r_awready;
  logic               r_wready;
  logic               r_bvalid;
  logic [1:0]         r_bresp;
  logic               r_wr_pulse;
  logic [IDX_W-1:0]   r_wr_index;

  logic               w_aw_hs;
  logic               w_w_hs;
  logic [ADDR_W-3:0]  w_idx_full;
  logic               w_in_range;
  logic               w_misaligned;
  logic               w_ok;
  logic               w_we;

  assign w_aw_hs    = AWVALID & r_awready;
  assign w_w_hs     = WVALID & r_wready;
  assign w_idx_full = r_awaddr[ADDR_W-1:2];
  assign w_in_range = {1'b0, w_idx_full} < NUM_REGS_L;

`ifdef AXIL_ALIGN_CHECK_EN
  assign w_misaligned = (r_awaddr[1:0] != 2'b00);
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^r_awaddr[1:0];
  assign w_misaligned = 1'b0;
`endif

  assign w_ok = w_in_range & ~w_misaligned;
  assign w_we = (r_state == COMMIT) & w_ok;

  // Ready flags are registered so reset can hold them low; they re-open one edge after release.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state    <= IDLE;
      r_aw_cap   <= 1'b0;
      r_w_cap    <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= 1'b0;
      r_wr_index <= '0;
    end else begin
      r_wr_pulse <= w_we;
      case (r_state)
        IDLE: begin
          if (w_aw_hs) begin
            r_awaddr <= AWADDR;
            r_aw_cap <= 1'b1;
          end
          if (w_w_hs) begin
            r_wdata <= WDATA;
            r_wstrb <= WSTRB;
            r_w_cap <= 1'b1;
          end
          r_awready <= ~(r_aw_cap | w_aw_hs);
          r_wready  <= ~(r_w_cap | w_w_hs);
          if (r_aw_cap && r_w_cap) begin
            r_state <= COMMIT;
          end
        end
        COMMIT: begin
          r_aw_cap  <= 1'b0;
          r_w_cap   <= 1'b0;
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b1;
          r_bresp   <= w_ok ? RESP_OKAY : RESP_SLVERR;
          if (w_we) begin
            r_wr_index <= w_idx_full[IDX_W-1:0];
          end
          r_state <= RESP;
        end
        RESP: begin
          if (BREADY) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  axil_strb_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .i_clk     (ACLK),
    .i_resetn  (ARESETn),
    .i_we      (w_we),
    .i_idx     (w_idx_full[IDX_W-1:0]),
    .i_wdata   (r_wdata),
    .i_wstrb   (r_wstrb),
    .i_rd_idx  (rd_idx),
    .o_rd_data (rd_data)
  );

  assign AWREADY  = r_awready;
  assign WREADY   = r_wready;
  assign BVALID   = r_bvalid;
  assign BRESP    = r_bresp;
  assign wr_pulse = r_wr_pulse;
  assign wr_index = r_wr_index;

endmodule

// File: tb/tb_axil_write_slave_ctrl.sv
// tb/tb_axil_write_slave_ctrl.sv - directed table-driven bench for axil_write_slave_ctrl
module tb_axil_write_slave_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [7:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic        wr_pulse;
  logic [3:0]  wr_index;
  logic [3:0]  rd_idx;
  logic [31:0] rd_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  axil_write_slave_ctrl #(.ADDR_W(8), .NUM_REGS(16)) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .AWADDR   (AWADDR),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .BRESP    (BRESP),
    .wr_pulse (wr_pulse),
    .wr_index (wr_index),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        pulse;
    logic [3:0]  idx;
    logic [1:0]  resp;
    logic [3:0]  rd;
    logic [31:0] rd_exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic read_chk(input string name, input logic [3:0] idx, input logic [31:0] exp);
    rd_idx = idx;
    #1;
    chk(name, rd_data, exp);
  endtask

  // Called just after the edge where the last of AW/W was captured.
  task automatic finish_resp(input string tag, input logic pulse, input logic [3:0] idx,
                             input logic [1:0] resp, input bit stall);
    @(negedge ACLK);
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    chk({tag, " bvalid t+0"}, 32'(BVALID), 32'd0);
    cyc();
    chk({tag, " bvalid t+1"}, 32'(BVALID), 32'd0);
    chk({tag, " pulse t+1"}, 32'(wr_pulse), 32'd0);
    cyc();
    chk({tag, " bvalid t+2"}, 32'(BVALID), 32'd1);
    chk({tag, " bresp"}, 32'(BRESP), 32'(resp));
    chk({tag, " wr_pulse"}, 32'(wr_pulse), 32'(pulse));
    if (pulse) chk({tag, " wr_index"}, 32'(wr_index), 32'(idx));
    if (!stall) begin
      cyc();
      chk({tag, " bvalid after B"}, 32'(BVALID), 32'd0);
      chk({tag, " bresp after B"}, 32'(BRESP), 32'd0);
      chk({tag, " rdy after B"}, {30'd0, AWREADY, WREADY}, 32'd3);
    end
  endtask

  task automatic do_write(input string tag, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic pulse, input logic [3:0] idx,
                          input logic [1:0] resp);
    AWADDR  = a;
    WDATA   = d;
    WSTRB   = s;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    BREADY  = 1'b1;
    chk({tag, " rdy before"}, {30'd0, AWREADY, WREADY}, 32'd3);
    @(posedge ACLK);
    finish_resp(tag, pulse, idx, resp, 1'b0);
  endtask

  initial begin
    vecs[0] = '{8'h08, 32'hDEADBEEF, 4'hF, 1'b1, 4'd2,  2'b00, 4'd2,  32'hDEADBEEF};
    vecs[1] = '{8'h04, 32'hAAAAAAAA, 4'hF, 1'b1, 4'd1,  2'b00, 4'd1,  32'hAAAAAAAA};
    vecs[2] = '{8'h40, 32'h12345678, 4'hF, 1'b0, 4'd0,  2'b10, 4'd2,  32'hDEADBEEF};
    vecs[3] = '{8'h08, 32'h00000000, 4'h0, 1'b1, 4'd2,  2'b00, 4'd2,  32'hDEADBEEF};
    vecs[4] = '{8'h08, 32'h55667788, 4'h8, 1'b1, 4'd2,  2'b00, 4'd2,  32'h55ADBEEF};
    vecs[5] = '{8'h3C, 32'hFFFFFFFF, 4'h3, 1'b1, 4'd15, 2'b00, 4'd15, 32'h0000FFFF};
    vecs[6] = '{8'hFC, 32'h99999999, 4'hF, 1'b0, 4'd0,  2'b10, 4'd15, 32'h0000FFFF};
`ifdef AXIL_ALIGN_CHECK_EN
    vecs[7] = '{8'h05, 32'h01020304, 4'hF, 1'b0, 4'd0,  2'b10, 4'd1,  32'hAAAAAAAA};
`else
    vecs[7] = '{8'h05, 32'h01020304, 4'hF, 1'b1, 4'd1,  2'b00, 4'd1,  32'h01020304};
`endif

    ARESETn = 1'b0;
    AWADDR  = '0;
    AWVALID = 1'b0;
    WDATA   = '0;
    WSTRB   = '0;
    WVALID  = 1'b0;
    BREADY  = 1'b0;
    rd_idx  = '0;
    cyc();
    cyc();
    chk("reset outputs", {24'd0, AWREADY, WREADY, BVALID, BRESP, wr_pulse, 2'b00},
        32'd0);
    chk("reset wr_index", 32'(wr_index), 32'd0);
    read_chk("reset reg0", 4'd0, 32'd0);
    ARESETn = 1'b1;
    cyc();
    chk("ready after release", {30'd0, AWREADY, WREADY}, 32'd3);

    for (int i = 0; i < 8; i++) begin
      do_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb,
               vecs[i].pulse, vecs[i].idx, vecs[i].resp);
      read_chk($sformatf("vec%0d rd", i), vecs[i].rd, vecs[i].rd_exp);
    end

    // W leads AW by three cycles into a preset register.
    do_write("preset1", 8'h04, 32'hAAAAAAAA, 4'hF, 1'b1, 4'd1, 2'b00);
    WDATA  = 32'h11223344;
    WSTRB  = 4'b0101;
    WVALID = 1'b1;
    @(posedge ACLK);
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      WVALID = 1'b0;
      chk($sformatf("wfirst rdy %0d", k), {30'd0, AWREADY, WREADY}, 32'd2);
      chk($sformatf("wfirst bvalid %0d", k), 32'(BVALID), 32'd0);
      if (k < 2) @(posedge ACLK);
    end
    AWADDR  = 8'h04;
    AWVALID = 1'b1;
    @(posedge ACLK);
    finish_resp("wfirst", 1'b1, 4'd1, 2'b00, 1'b0);
    read_chk("wfirst reg1", 4'd1, 32'hAA22AA44);

    // AW first, then a 5-cycle BREADY stall with a new write already presented.
    BREADY  = 1'b0;
    AWADDR  = 8'h0C;
    AWVALID = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("awfirst rdy", {30'd0, AWREADY, WREADY}, 32'd1);
    WDATA  = 32'hCAFEF00D;
    WSTRB  = 4'hF;
    WVALID = 1'b1;
    @(posedge ACLK);
    finish_resp("stall", 1'b1, 4'd3, 2'b00, 1'b1);
    AWADDR  = 8'h10;
    AWVALID = 1'b1;
    WDATA   = 32'h0F0F0F0F;
    WVALID  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("stall bvalid %0d", k), 32'(BVALID), 32'd1);
      chk($sformatf("stall bresp %0d", k), 32'(BRESP), 32'd0);
      chk($sformatf("stall rdy %0d", k), {30'd0, AWREADY, WREADY}, 32'd0);
    end
    BREADY = 1'b1;
    #1;
    chk("stall rdy at BREADY rise", {30'd0, AWREADY, WREADY}, 32'd0);
    cyc();
    chk("stall bvalid after B", 32'(BVALID), 32'd0);
    chk("stall rdy after B", {30'd0, AWREADY, WREADY}, 32'd3);
    @(posedge ACLK);
    finish_resp("post-stall", 1'b1, 4'd4, 2'b00, 1'b0);
    read_chk("stall reg3", 4'd3, 32'hCAFEF00D);
    read_chk("stall reg4", 4'd4, 32'h0F0F0F0F);

    // Reset while BVALID is held.
    BREADY  = 1'b0;
    AWADDR  = 8'h20;
    WDATA   = 32'h77777777;
    WSTRB   = 4'hF;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    @(posedge ACLK);
    finish_resp("rstresp", 1'b1, 4'd8, 2'b00, 1'b1);
    ARESETn = 1'b0;
    cyc();
    chk("rst bvalid", 32'(BVALID), 32'd0);
    chk("rst rdy", {30'd0, AWREADY, WREADY}, 32'd0);
    chk("rst pulse", 32'(wr_pulse), 32'd0);
    read_chk("rst reg8", 4'd8, 32'd0);
    read_chk("rst reg3", 4'd3, 32'd0);
    ARESETn = 1'b1;
    BREADY  = 1'b1;
    cyc();
    chk("rst release rdy", {30'd0, AWREADY, WREADY}, 32'd3);
    do_write("fresh", 8'h08, 32'h0BADF00D, 4'hF, 1'b1, 4'd2, 2'b00);
    read_chk("fresh reg2", 4'd2, 32'h0BADF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
